rstn_release_seq: RTL and testbench



---
 rtl/rstn_release_seq.sv | 105 ++++++++++
 tb/tb_rstn_release_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rstn_release_seq.sv
// rstn_release_seq
// Generates staged active-low resets for banks of async-clear flops.
// R clears every output at once, with no clock involved. Once R falls, the
// deassertion is synchronised to CLK. RN[0] is then held low for HOLD_CYCLES
// edges. After that, the remaining domains are released one at a time in
// ascending order, STAGE_GAP edges apart.
// SWRST replays the hold and release part of the sequence without passing
// through the synchroniser again.
module rstn_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NDOM        = 4,
  parameter int STAGE_GAP   = 4
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            SWRST,
  output logic [NDOM-1:0] RN,
  output logic            READY,
  output logic            SOFT_CAUSE
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NDOM + 1);

  // The counter is cleared on entry to a state, so terminal values sit one below the interval.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDOM - 1);
  localparam logic [IW-1:0] IDX_FIRST = IW'(1);

  typedef enum logic [1:0] {SYNC, HOLD, RELEASE, RUN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;

  // Sequencer: async clear on R; otherwise sync -> hold -> staged release -> run, with SWRST restarting at hold
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state      <= SYNC;
      sync       <= '1;
      RN         <= '0;
      READY      <= 1'b0;
      SOFT_CAUSE <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b0};
      if (state != SYNC && SWRST) begin
        state      <= HOLD;
        RN         <= '0;
        READY      <= 1'b0;
        SOFT_CAUSE <= 1'b1;
        cnt        <= '0;
        idx        <= '0;
      end else begin
        case (state)
          SYNC: begin
            if (!sync[SYNC_STAGES-2] && sync[SYNC_STAGES-1]) begin
              state <= HOLD;
              cnt   <= '0;
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              RN  <= NDOM'(1);
              cnt <= '0;
              if (NDOM == 1) begin
                READY <= 1'b1;
                state <= RUN;
                idx   <= '0;
              end else begin
                state <= RELEASE;
                idx   <= IDX_FIRST;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == GAP_LAST) begin
              RN  <= RN | (NDOM'(1) << idx);
              cnt <= '0;
              if (idx == IDX_LAST) begin
                READY <= 1'b1;
                state <= RUN;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rstn_release_seq.sv
// tb_rstn_release_seq
// Drives two instances from the same R/SWRST:
//   - a default-parameter instance;
//   - a NDOM=1, HOLD_CYCLES=1, SYNC_STAGES=3 instance.
// Both are compared against an edge-count model of the release schedule.
module tb_rstn_release_seq;

  logic       CLK = 1'b0;
  logic       R;
  logic       SWRST;
  logic [3:0] rn_a;
  logic       ready_a;
  logic       soft_a;
  logic [0:0] rn_b;
  logic       ready_b;
  logic       soft_b;

  int compared   = 0;
  int mismatched = 0;

  // Model state per instance:
  //   m_cnt  = edges counted since the sequence anchor;
  //   m_off  = sync latency still owed (0 after a soft reset);
  //   m_soft = reset cause.
  int m_cnt  [2];
  int m_off  [2];
  bit m_soft [2];

  always #5 CLK = ~CLK;

  rstn_release_seq dut_a (
    .CLK        (CLK),
    .R          (R),
    .SWRST      (SWRST),
    .RN         (rn_a),
    .READY      (ready_a),
    .SOFT_CAUSE (soft_a)
  );

  rstn_release_seq #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .NDOM        (1),
    .STAGE_GAP   (1)
  ) dut_b (
    .CLK        (CLK),
    .R          (R),
    .SWRST      (SWRST),
    .RN         (rn_b),
    .READY      (ready_b),
    .SOFT_CAUSE (soft_b)
  );

  function automatic int p_sync(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int p_hold(int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic int p_ndom(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int p_gap(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Domain i is released once the count passes sync latency + hold + i gaps.
  function automatic logic [3:0] exp_rn(int d);
    logic [3:0] v;
    v = 4'b0000;
    for (int i = 0; i < p_ndom(d); i++)
      if (m_cnt[d] >= m_off[d] + p_hold(d) + i * p_gap(d)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ready(int d);
    return m_cnt[d] >= m_off[d] + p_hold(d) + (p_ndom(d) - 1) * p_gap(d);
  endfunction

  // Reference model: R restarts the count with sync latency, and SWRST restarts it without.
  // SWRST seen while the synchroniser is still draining is ignored.
  always @(posedge CLK or posedge R) begin
    if (R) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d]  = 0;
        m_off[d]  = p_sync(d);
        m_soft[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (SWRST && !(m_off[d] > 0 && m_cnt[d] < m_off[d])) begin
          m_cnt[d]  = 0;
          m_off[d]  = 0;
          m_soft[d] = 1'b1;
        end else if (m_cnt[d] < 100000) begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag);
    logic [3:0] e_rn_a;
    logic [3:0] e_rn_b;
    logic       e_rdy_a;
    logic       e_rdy_b;
    e_rn_a  = exp_rn(0);
    e_rn_b  = exp_rn(1);
    e_rdy_a = exp_ready(0);
    e_rdy_b = exp_ready(1);

    compared++;
    assert (rn_a === e_rn_a) else begin
      mismatched++;
      $error("[TB] FAIL %s rn_a observed=%b expected=%b", tag, rn_a, e_rn_a);
    end

    compared++;
    assert (ready_a === e_rdy_a) else begin
      mismatched++;
      $error("[TB] FAIL %s ready_a observed=%b expected=%b", tag, ready_a, e_rdy_a);
    end

    compared++;
    assert (soft_a === m_soft[0]) else begin
      mismatched++;
      $error("[TB] FAIL %s soft_a observed=%b expected=%b", tag, soft_a, m_soft[0]);
    end

    compared++;
    assert (rn_b === e_rn_b[0]) else begin
      mismatched++;
      $error("[TB] FAIL %s rn_b observed=%b expected=%b", tag, rn_b, e_rn_b[0]);
    end

    compared++;
    assert (ready_b === e_rdy_b) else begin
      mismatched++;
      $error("[TB] FAIL %s ready_b observed=%b expected=%b", tag, ready_b, e_rdy_b);
    end

    compared++;
    assert (soft_b === m_soft[1]) else begin
      mismatched++;
      $error("[TB] FAIL %s soft_b observed=%b expected=%b", tag, soft_b, m_soft[1]);
    end
  endtask

  // Fixed spot values taken directly from the documented schedule.
  task automatic checkConst(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Hold R/SWRST for n edges, checking 2 time units after each edge.
  task automatic applyStimulus(input logic r_val, input logic sw_val, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      R     = r_val;
      SWRST = sw_val;
      @(posedge CLK);
      #2;
      checkOutput(tag);
    end
  endtask

  // Raise R between edges and check that outputs clear before any clock edge.
  task automatic asyncReset(input string tag);
    #3;
    R = 1'b1;
    #1;
    checkOutput(tag);
    checkConst({tag, "_clear"}, {rn_a, ready_a}, 5'b00000);
  endtask

  initial begin
    R     = 1'b1;
    SWRST = 1'b0;

    // Power-on: RN bits rise after edges 18, 22, 26 and 30.
    applyStimulus(1'b1, 1'b0, 5, "por_hold");
    applyStimulus(1'b0, 1'b0, 17, "por_seq");
    checkConst("por_e17", {rn_a, ready_a}, 5'b00000);
    applyStimulus(1'b0, 1'b0, 1, "por_seq");
    checkConst("por_e18", {rn_a, ready_a}, 5'b00010);
    applyStimulus(1'b0, 1'b0, 12, "por_seq");
    checkConst("por_e30", {rn_a, ready_a}, 5'b11111);
    applyStimulus(1'b0, 1'b0, 3, "por_run");

    // Single-cycle SWRST in RUN.
    applyStimulus(1'b0, 1'b1, 1, "sw_pulse");
    checkConst("sw_pulse_soft", {4'b0000, soft_a}, 5'b00001);
    applyStimulus(1'b0, 1'b0, 32, "sw_pulse_seq");

    // SWRST held for ten sampled edges.
    applyStimulus(1'b0, 1'b1, 10, "sw_held");
    applyStimulus(1'b0, 1'b0, 32, "sw_held_seq");

    // Async R while RN[1:0] are already released (after edge 24).
    applyStimulus(1'b1, 1'b0, 2, "r_mid_pre");
    applyStimulus(1'b0, 1'b0, 24, "r_mid_seq");
    checkConst("r_mid_e24", {rn_a, ready_a}, 5'b00110);
    asyncReset("r_mid_async");
    applyStimulus(1'b1, 1'b0, 1, "r_mid_hold");
    applyStimulus(1'b0, 1'b0, 35, "r_mid_rerun");

    // SWRST during RELEASE at edge 23, then re-release after edge 39.
    applyStimulus(1'b1, 1'b0, 2, "sw_rel_pre");
    applyStimulus(1'b0, 1'b0, 22, "sw_rel_seq");
    checkConst("sw_rel_e22", {rn_a, ready_a}, 5'b00110);
    applyStimulus(1'b0, 1'b1, 1, "sw_rel_e23");
    checkConst("sw_rel_clear", {rn_a, ready_a}, 5'b00000);
    applyStimulus(1'b0, 1'b0, 16, "sw_rel_rerun");
    checkConst("sw_rel_e39", {rn_a, ready_a}, 5'b00010);
    applyStimulus(1'b0, 1'b0, 14, "sw_rel_tail");

    // Randomised mix of async R pulses, SWRST bursts (R high while SWRST high too) and idle runs.
    for (int k = 0; k < 400; k++) begin
      int roll;
      roll = $urandom_range(0, 99);
      if (roll < 3) begin
        asyncReset("rnd_r");
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3), "rnd_r_hold");
      end else if (roll < 15) begin
        applyStimulus(1'b0, 1'b1, $urandom_range(1, 12), "rnd_sw");
      end else begin
        applyStimulus(1'b0, 1'b0, $urandom_range(1, 10), "rnd_idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
